// File: rtl/upg_boot_pkg.sv
// upg_boot_pkg: shared types and widths for the boot/programming sequencer.
// State encoding is visible on state_o, so the values are fixed.
package upg_boot_pkg;

  typedef enum logic [1:0] {
    HOLD  = 2'd0,
    RUN   = 2'd1,
    PROG  = 2'd2,
    FLUSH = 2'd3
  } upg_state_e;

  localparam int MEM_SEL_BIT = 14;
  localparam int MEM_ADR_W   = 14;
  localparam int WORD_CNT_W  = 16;
  localparam int UPG_ADR_W   = 15;
  localparam int DATA_W      = 32;

  function automatic logic [WORD_CNT_W-1:0] sat_inc(
    input logic [WORD_CNT_W-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/upg_boot_if.sv
// upg_boot_if: UART programmer write port and the memory write port.
// master = programmer/memory side, slave = upg_boot_ctrl.
interface upg_boot_if;
  import upg_boot_pkg::*;

  logic                  upg_wen_i;
  logic [UPG_ADR_W-1:0]  upg_adr_i;
  logic [DATA_W-1:0]     upg_dat_i;
  logic                  upg_done_i;
  logic                  upg_rst_o;
  logic                  imem_wen_o;
  logic                  dmem_wen_o;
  logic [MEM_ADR_W-1:0]  mem_adr_o;
  logic [DATA_W-1:0]     mem_dat_o;

  modport master (
    output upg_wen_i, upg_adr_i, upg_dat_i, upg_done_i,
    input  upg_rst_o, imem_wen_o, dmem_wen_o, mem_adr_o, mem_dat_o
  );

  modport slave (
    input  upg_wen_i, upg_adr_i, upg_dat_i, upg_done_i,
    output upg_rst_o, imem_wen_o, dmem_wen_o, mem_adr_o, mem_dat_o
  );

endinterface

// File: rtl/upg_boot_ctrl_key_debounce.sv
// key_debounce: 2-flop synchronizer, stability counter, registered
// one-cycle pulse on the accepted 0->1 edge of the debounced level.
module key_debounce #(
  parameter int unsigned CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_i,
  output logic pulse_o
);

  localparam int unsigned CW =
    ($clog2(CYCLES) > 0) ? $clog2(CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CYCLES - 1);

  logic          sync0_q, sync0_d;
  logic          sync1_q, sync1_d;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pulse_q, pulse_d;

  always_comb begin
    sync0_d = key_i;
    sync1_d = sync0_q;
    level_d = level_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    // counts consecutive cycles the synced input disagrees with level
    if (sync1_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      level_d = sync1_q;
      cnt_d   = '0;
      pulse_d = sync1_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync0_q <= 1'b0;
      sync1_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      sync0_q <= sync0_d;
      sync1_q <= sync1_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/upg_boot_ctrl.sv
// upg_boot_ctrl: CPU/UART-programmer arbitration and boot sequencer.
// Optional programmer watchdog: define UPG_WATCHDOG_EN.
module upg_boot_ctrl
  import upg_boot_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned RST_HOLD_CYCLES = 16,
  parameter int unsigned TIMEOUT_CYCLES  = 50_000_000
) (
  input  logic                  fpga_clk,
  input  logic                  fpga_rst_n,
  input  logic                  start_pg,
  upg_boot_if.slave             bus,
  output logic                  cpu_rst_o,
  output logic [WORD_CNT_W-1:0] word_cnt_o,
  output logic [1:0]            state_o,
  output logic                  err_o
);

  localparam int unsigned HW =
    ($clog2(RST_HOLD_CYCLES) > 0) ? $clog2(RST_HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_MAX = HW'(RST_HOLD_CYCLES - 1);

  logic btn_pulse;

  key_debounce #(
    .CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk     (fpga_clk),
    .rst_n   (fpga_rst_n),
    .key_i   (start_pg),
    .pulse_o (btn_pulse)
  );

  upg_state_e            state_q, state_d;
  logic [HW-1:0]         hold_q, hold_d;
  logic                  cpu_rst_q, cpu_rst_d;
  logic                  upg_rst_q, upg_rst_d;
  logic                  imem_q, imem_d;
  logic                  dmem_q, dmem_d;
  logic [MEM_ADR_W-1:0]  adr_q, adr_d;
  logic [DATA_W-1:0]     dat_q, dat_d;
  logic [WORD_CNT_W-1:0] cnt_q, cnt_d;
  logic                  timeout;

`ifdef UPG_WATCHDOG_EN
  localparam int unsigned GW =
    ($clog2(TIMEOUT_CYCLES) > 0) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_MAX = GW'(TIMEOUT_CYCLES - 1);

  logic [GW-1:0] gap_q, gap_d;
  logic          err_q, err_d;

  assign timeout = (gap_q == GAP_MAX);
`else
  assign timeout = 1'b0;
`endif

  logic wen;
  logic sel_dmem;

  assign wen      = bus.upg_wen_i;
  assign sel_dmem = bus.upg_adr_i[MEM_SEL_BIT];

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    imem_d  = 1'b0;
    dmem_d  = 1'b0;
    adr_d   = adr_q;
    dat_d   = dat_q;
    cnt_d   = cnt_q;
`ifdef UPG_WATCHDOG_EN
    gap_d   = gap_q;
    err_d   = err_q;
`endif
    unique case (state_q)
      HOLD: begin
        if (hold_q == HOLD_MAX) begin
          state_d = RUN;
          hold_d  = '0;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      RUN: begin
        if (btn_pulse) begin
          state_d = PROG;
          cnt_d   = '0;
`ifdef UPG_WATCHDOG_EN
          gap_d   = '0;
          err_d   = 1'b0;
`endif
        end
      end
      PROG: begin
        if (wen) begin
          imem_d = !sel_dmem;
          dmem_d = sel_dmem;
          adr_d  = bus.upg_adr_i[MEM_ADR_W-1:0];
          dat_d  = bus.upg_dat_i;
          cnt_d  = sat_inc(cnt_q);
        end
`ifdef UPG_WATCHDOG_EN
        gap_d = wen ? '0 : gap_q + 1'b1;
`endif
        // done wins over the watchdog; a write alongside done still lands
        if (bus.upg_done_i) begin
          state_d = FLUSH;
        end else if (!wen && timeout) begin
          state_d = FLUSH;
`ifdef UPG_WATCHDOG_EN
          err_d   = 1'b1;
`endif
        end
      end
      FLUSH: begin
        state_d = HOLD;
        hold_d  = '0;
      end
      default: state_d = HOLD;
    endcase
    cpu_rst_d = (state_d != RUN);
    upg_rst_d = (state_d == HOLD) || (state_d == RUN);
  end

  always_ff @(posedge fpga_clk or negedge fpga_rst_n) begin
    if (!fpga_rst_n) begin
      state_q   <= HOLD;
      hold_q    <= '0;
      cpu_rst_q <= 1'b1;
      upg_rst_q <= 1'b1;
      imem_q    <= 1'b0;
      dmem_q    <= 1'b0;
      adr_q     <= '0;
      dat_q     <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      cpu_rst_q <= cpu_rst_d;
      upg_rst_q <= upg_rst_d;
      imem_q    <= imem_d;
      dmem_q    <= dmem_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      cnt_q     <= cnt_d;
    end
  end

`ifdef UPG_WATCHDOG_EN
  always_ff @(posedge fpga_clk or negedge fpga_rst_n) begin
    if (!fpga_rst_n) begin
      gap_q <= '0;
      err_q <= 1'b0;
    end else begin
      gap_q <= gap_d;
      err_q <= err_d;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  assign bus.upg_rst_o  = upg_rst_q;
  assign bus.imem_wen_o = imem_q;
  assign bus.dmem_wen_o = dmem_q;
  assign bus.mem_adr_o  = adr_q;
  assign bus.mem_dat_o  = dat_q;
  assign cpu_rst_o      = cpu_rst_q;
  assign word_cnt_o     = cnt_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_upg_boot_ctrl.sv
// tb_upg_boot_ctrl: directed bench with a cycle model of the sequencer
// and per-cycle output comparison, plus literal spot checks.
module tb_upg_boot_ctrl;

  localparam int DEB = 4;
  localparam int RH  = 3;
  localparam int TO  = 20;
`ifdef UPG_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic        fpga_clk = 1'b0;
  logic        fpga_rst_n;
  logic        start_pg;
  logic        cpu_rst_o;
  logic [15:0] word_cnt_o;
  logic [1:0]  state_o;
  logic        err_o;

  upg_boot_if bus();

  upg_boot_ctrl #(
    .DEBOUNCE_CYCLES (DEB),
    .RST_HOLD_CYCLES (RH),
    .TIMEOUT_CYCLES  (TO)
  ) dut (
    .fpga_clk   (fpga_clk),
    .fpga_rst_n (fpga_rst_n),
    .start_pg   (start_pg),
    .bus        (bus),
    .cpu_rst_o  (cpu_rst_o),
    .word_cnt_o (word_cnt_o),
    .state_o    (state_o),
    .err_o      (err_o)
  );

  always #5 fpga_clk = ~fpga_clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: states 0 hold, 1 run, 2 prog, 3 flush
  int          m_state, m_hold, m_cnt, m_gap, m_run;
  bit          m_err, m_imem, m_dmem, m_lev, acc;
  bit [2:0]    m_pipe;
  logic [13:0] m_adr;
  logic [31:0] m_dat;
  bit          s_start, s_wen, s_done;
  logic [14:0] s_adr;
  logic [31:0] s_dat;

  task automatic model_reset();
    m_state = 0; m_hold = 0; m_cnt = 0; m_gap = 0; m_run = 0;
    m_err = 0; m_imem = 0; m_dmem = 0; m_lev = 0; m_pipe = '0;
    m_adr = '0; m_dat = '0;
  endtask

  always @(posedge fpga_clk) begin
    s_start = start_pg;
    s_wen   = bus.upg_wen_i;
    s_done  = bus.upg_done_i;
    s_adr   = bus.upg_adr_i;
    s_dat   = bus.upg_dat_i;
    if (!fpga_rst_n) begin
      model_reset();
    end else begin
      // accepted press reaches the FSM 3 edges after the DEB-th sample
      acc    = m_pipe[2];
      m_pipe = {m_pipe[1:0], 1'b0};
      if (s_start != m_lev) begin
        m_run++;
        if (m_run == DEB) begin
          m_lev     = s_start;
          m_run     = 0;
          m_pipe[0] = s_start;
        end
      end else begin
        m_run = 0;
      end
      m_imem = 0;
      m_dmem = 0;
      case (m_state)
        0: begin
          if (m_hold == RH - 1) begin m_state = 1; m_hold = 0; end
          else m_hold++;
        end
        1: if (acc) begin
          m_state = 2; m_cnt = 0; m_err = 0; m_gap = 0;
        end
        2: begin
          if (s_wen) begin
            if (s_adr[14]) m_dmem = 1; else m_imem = 1;
            m_adr = s_adr[13:0];
            m_dat = s_dat;
            if (m_cnt < 16'hFFFF) m_cnt++;
            m_gap = 0;
          end else begin
            m_gap++;
          end
          if (s_done) m_state = 3;
          else if (WD && !s_wen && m_gap == TO) begin
            m_state = 3; m_err = 1;
          end
        end
        default: begin m_state = 0; m_hold = 0; end
      endcase
    end
    #1;
    chk("state", 32'(state_o), 32'(m_state));
    chk("cpu_rst", 32'(cpu_rst_o), 32'(m_state != 1));
    chk("upg_rst", 32'(bus.upg_rst_o), 32'(m_state <= 1));
    chk("imem_wen", 32'(bus.imem_wen_o), 32'(m_imem));
    chk("dmem_wen", 32'(bus.dmem_wen_o), 32'(m_dmem));
    chk("mem_adr", 32'(bus.mem_adr_o), 32'(m_adr));
    chk("mem_dat", bus.mem_dat_o, m_dat);
    chk("word_cnt", 32'(word_cnt_o), 32'(m_cnt));
    chk("err", 32'(err_o), 32'(m_err));
  end

  task automatic step();
    @(posedge fpga_clk);
    #2;
  endtask

  task automatic press();
    @(negedge fpga_clk) start_pg = 1'b1;
    repeat (6) step();
    @(negedge fpga_clk) start_pg = 1'b0;
    step();
    chk("press_state", 32'(state_o), 32'd2);
    chk("press_cnt_clr", 32'(word_cnt_o), 32'd0);
    chk("press_err_clr", 32'(err_o), 32'd0);
  endtask

  initial begin
    fpga_rst_n     = 1'b0;
    start_pg       = 1'b0;
    bus.upg_wen_i  = 1'b0;
    bus.upg_adr_i  = '0;
    bus.upg_dat_i  = '0;
    bus.upg_done_i = 1'b0;
    repeat (3) step();
    chk("rst_cpu", 32'(cpu_rst_o), 32'd1);
    chk("rst_upg", 32'(bus.upg_rst_o), 32'd1);
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_adr", 32'(bus.mem_adr_o), 32'd0);

    @(negedge fpga_clk) fpga_rst_n = 1'b1;
    step();
    step();
    chk("hold_cpu_rst", 32'(cpu_rst_o), 32'd1);
    step();
    chk("run_cpu_rst", 32'(cpu_rst_o), 32'd0);
    chk("run_state", 32'(state_o), 32'd1);
    chk("run_upg_rst", 32'(bus.upg_rst_o), 32'd1);

    @(negedge fpga_clk) start_pg = 1'b1;
    step();
    step();
    @(negedge fpga_clk) start_pg = 1'b0;
    repeat (6) step();
    chk("short_pulse", 32'(state_o), 32'd1);

    press();
    chk("prog_upg_rst", 32'(bus.upg_rst_o), 32'd0);
    chk("prog_cpu_rst", 32'(cpu_rst_o), 32'd1);

    @(negedge fpga_clk);
    bus.upg_wen_i = 1'b1;
    bus.upg_adr_i = 15'h0003;
    bus.upg_dat_i = 32'hDEADBEEF;
    step();
    chk("w1_imem", 32'(bus.imem_wen_o), 32'd1);
    chk("w1_dmem", 32'(bus.dmem_wen_o), 32'd0);
    chk("w1_adr", 32'(bus.mem_adr_o), 32'd3);
    chk("w1_dat", bus.mem_dat_o, 32'hDEADBEEF);
    @(negedge fpga_clk);
    bus.upg_adr_i = 15'h4005;
    bus.upg_dat_i = 32'h12345678;
    step();
    chk("w2_imem", 32'(bus.imem_wen_o), 32'd0);
    chk("w2_dmem", 32'(bus.dmem_wen_o), 32'd1);
    chk("w2_adr", 32'(bus.mem_adr_o), 32'd5);
    chk("w2_cnt", 32'(word_cnt_o), 32'd2);
    @(negedge fpga_clk) bus.upg_wen_i = 1'b0;
    step();
    chk("idle_dmem", 32'(bus.dmem_wen_o), 32'd0);
    chk("idle_adr_hold", 32'(bus.mem_adr_o), 32'd5);

    @(negedge fpga_clk);
    bus.upg_wen_i  = 1'b1;
    bus.upg_adr_i  = 15'h0007;
    bus.upg_dat_i  = 32'hCAFEF00D;
    bus.upg_done_i = 1'b1;
    step();
    chk("flush_state", 32'(state_o), 32'd3);
    chk("flush_imem", 32'(bus.imem_wen_o), 32'd1);
    chk("flush_adr", 32'(bus.mem_adr_o), 32'd7);
    chk("flush_cnt", 32'(word_cnt_o), 32'd3);
    @(negedge fpga_clk);
    bus.upg_wen_i  = 1'b0;
    bus.upg_done_i = 1'b0;
    step();
    chk("fh1_state", 32'(state_o), 32'd0);
    chk("fh1_imem", 32'(bus.imem_wen_o), 32'd0);
    step();
    step();
    chk("fh3_state", 32'(state_o), 32'd0);
    step();
    chk("fr_state", 32'(state_o), 32'd1);
    chk("fr_cnt_kept", 32'(word_cnt_o), 32'd3);

    press();
    @(negedge fpga_clk);
    bus.upg_wen_i = 1'b1;
    bus.upg_adr_i = 15'h4010;
    bus.upg_dat_i = 32'h0BADF00D;
    step();
    @(negedge fpga_clk) bus.upg_wen_i = 1'b0;
    repeat (20) step();
`ifdef UPG_WATCHDOG_EN
    chk("wd_state", 32'(state_o), 32'd3);
    chk("wd_err", 32'(err_o), 32'd1);
    step();
    chk("wd_hold", 32'(state_o), 32'd0);
    repeat (3) step();
    chk("wd_run", 32'(state_o), 32'd1);
    chk("wd_err_sticky", 32'(err_o), 32'd1);
`else
    chk("nowd_state", 32'(state_o), 32'd2);
    chk("nowd_err", 32'(err_o), 32'd0);
    @(negedge fpga_clk) bus.upg_done_i = 1'b1;
    step();
    @(negedge fpga_clk) bus.upg_done_i = 1'b0;
    repeat (4) step();
    chk("nowd_run", 32'(state_o), 32'd1);
`endif

    press();
    @(negedge fpga_clk);
    bus.upg_wen_i = 1'b1;
    bus.upg_adr_i = 15'h0002;
    bus.upg_dat_i = 32'hA5A5A5A5;
    step();
    chk("pre_rst_cnt", 32'(word_cnt_o), 32'd1);
    @(negedge fpga_clk);
    bus.upg_adr_i = 15'h4001;
    bus.upg_dat_i = 32'h55AA55AA;
    fpga_rst_n    = 1'b0;
    #1;
    chk("arst_state", 32'(state_o), 32'd0);
    chk("arst_cpu", 32'(cpu_rst_o), 32'd1);
    chk("arst_upg", 32'(bus.upg_rst_o), 32'd1);
    chk("arst_imem", 32'(bus.imem_wen_o), 32'd0);
    chk("arst_adr", 32'(bus.mem_adr_o), 32'd0);
    chk("arst_dat", bus.mem_dat_o, 32'd0);
    chk("arst_cnt", 32'(word_cnt_o), 32'd0);
    step();
    chk("arst_dmem", 32'(bus.dmem_wen_o), 32'd0);
    @(negedge fpga_clk);
    bus.upg_wen_i = 1'b0;
    fpga_rst_n    = 1'b1;
    repeat (4) step();
    chk("post_rst_run", 32'(state_o), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/upg_boot_ctrl.md
# upg_boot_ctrl

Boot and programming sequencer for the single-cycle MIPS CPU top level. It owns the arbitration between the running CPU and the UART programmer for the instruction and data memories. It debounces the program button, holds the CPU in reset while the UART programmer streams words, and steers each programmer write to instruction or data memory. It then releases the CPU through a fixed reset-hold window, replacing the ad-hoc `upg_rst` register logic at the top level.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, 1_000_000: stable cycles required on `start_pg` before it is accepted.
- `RST_HOLD_CYCLES`, 16: cycles `cpu_rst_o` stays high in HOLD.
- `TIMEOUT_CYCLES`, 50_000_000: maximum gap between programmer writes before abort (watchdog builds only).

Ports:
- `fpga_clk`, in, 1: single clock. All upg_* inputs are synchronous to it.
- `fpga_rst_n`, in, 1: asynchronous, active-low reset.
- `start_pg`, in, 1: raw program button, asynchronous.
- `upg_wen_i`, in, 1: programmer write strobe.
- `upg_adr_i`, in, 15: programmer word address. Bit 14 selects memory (0 = imem, 1 = dmem).
- `upg_dat_i`, in, 32: programmer write data.
- `upg_done_i`, in, 1: programmer transfer complete (level).
- `upg_rst_o`, out, 1: active-high reset to the UART programmer.
- `cpu_rst_o`, out, 1: active-high reset to Ifetc32/Idecode32.
- `imem_wen_o`, out, 1: programrom write enable.
- `dmem_wen_o`, out, 1: dmemory32 write enable.
- `mem_adr_o`, out, 14: word address to both memories.
- `mem_dat_o`, out, 32: write data to both memories.
- `word_cnt_o`, out, 16: words written in the current or last PROG session.
- `state_o`, out, 2: current state encoding.
- `err_o`, out, 1: sticky watchdog abort flag.

## Operation
- States: HOLD=0, RUN=1, PROG=2, FLUSH=3.
- **HOLD**
  - `cpu_rst_o`=1, `upg_rst_o`=1.
  - Hold counter loads 0 on entry and increments each cycle.
  - When it reaches `RST_HOLD_CYCLES`-1, go to RUN.
- **RUN**
  - `cpu_rst_o`=0, `upg_rst_o`=1.
  - An accepted button press (single-cycle pulse from the debouncer on the 0→1 debounced edge) goes to PROG.
  - On entry to PROG: `word_cnt_o` clears to 0 and `err_o` clears.
- **PROG**
  - `cpu_rst_o`=1, `upg_rst_o`=0.
  - Each cycle with `upg_wen_i`=1 registers `upg_adr_i[13:0]` and `upg_dat_i`.
  - It asserts `imem_wen_o` if `upg_adr_i[14]`=0, otherwise `dmem_wen_o`, for exactly one cycle.
  - `word_cnt_o` increments per write and saturates at 16'hFFFF.
  - `upg_done_i`=1 goes to FLUSH. A write in that same cycle is still captured.
  - Further button presses are ignored.
- **FLUSH**
  - Exactly one cycle.
  - Outputs as in PROG. The final registered write completes here.
  - Then go to HOLD.
- `imem_wen_o` and `dmem_wen_o` are never both 1. Both are 0 outside PROG and FLUSH.
- `mem_adr_o` and `mem_dat_o` hold their last value when no write is pending.

## Timing
- Reset values:
  - state HOLD, hold counter 0
  - `cpu_rst_o`=1, `upg_rst_o`=1
  - `imem_wen_o`=0, `dmem_wen_o`=0
  - `mem_adr_o`=0, `mem_dat_o`=0
  - `word_cnt_o`=0, `err_o`=0
- Write latency: programmer strobe at cycle N gives the memory write enable at cycle N+1. Address and data are registered alongside it.
- Button latency: `start_pg` stable high for `DEBOUNCE_CYCLES` gives the pulse. PROG is entered the next cycle, and `upg_rst_o` falls in that same cycle.
- HOLD lasts exactly `RST_HOLD_CYCLES` cycles. `cpu_rst_o` falls on the first RUN cycle.
- All outputs are registered. No combinational input-to-output path exists.
- `fpga_rst_n` asserted mid-PROG:
  - Immediately returns all outputs to their reset values.
  - An in-flight write is dropped.
  - The debouncer is cleared.

## Configuration
- `UPG_WATCHDOG_EN` defined:
  - In PROG, a gap counter clears on every write and on entry.
  - If it reaches `TIMEOUT_CYCLES` without `upg_done_i`, set `err_o`=1 and go to FLUSH, then HOLD.
  - `err_o` stays set until the next entry to PROG or reset.
- `UPG_WATCHDOG_EN` undefined:
  - No gap counter; PROG waits indefinitely.
  - `err_o` is tied to 0.

## Structure
- Package `upg_boot_pkg`:
  - State typedef: HOLD, RUN, PROG, FLUSH with the encodings above.
  - `MEM_SEL_BIT`=14.
  - `MEM_ADR_W`=14.
  - `WORD_CNT_W`=16.
- Sub-module `key_debounce`:
  - 2-flop synchronizer plus stability counter (width from `DEBOUNCE_CYCLES`).
  - Outputs a one-cycle rising-edge pulse.
  - Cleared asynchronously by `fpga_rst_n`.

## Test plan
Bench parameters for all scenarios: `DEBOUNCE_CYCLES`=4, `RST_HOLD_CYCLES`=3, `TIMEOUT_CYCLES`=20.
- **Reset release:** release `fpga_rst_n`. Expect `cpu_rst_o`=1 for 3 cycles, then 0; `state_o`=1; `upg_rst_o`=1 throughout.
- **Debounce:** in RUN, pulse `start_pg` for 2 cycles, then hold it for 6 cycles. Expect no transition on the short pulse; on the long hold, `state_o`=2 with `upg_rst_o`=0 and `cpu_rst_o`=1.
- **Routing:** in PROG, write adr 15'h0003 / data 32'hDEADBEEF, then adr 15'h4005 / data 32'h12345678. Expect:
  - `imem_wen_o` for 1 cycle with `mem_adr_o`=3.
  - Then `dmem_wen_o` for 1 cycle with `mem_adr_o`=5.
  - `word_cnt_o`=2.
- **Done with simultaneous write:** `upg_done_i` and a write in the same cycle. Expect:
  - The write appears at N+1 during FLUSH.
  - Then 3 HOLD cycles, then RUN.
  - `word_cnt_o` is retained after returning to RUN.
- **Watchdog (`UPG_WATCHDOG_EN`):** one write, then 20 idle cycles. Expect `err_o`=1, FLUSH, HOLD, RUN. In a build without the macro, PROG persists and `err_o`=0.
- **Mid-PROG reset:** assert `fpga_rst_n` low in the same cycle as a write. Expect no write enable and all outputs at reset values asynchronously.
